// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, issue, forwarding, write-back, flush
// and the sticky scoreboard error flag. The master drives the pipeline-side
// signals and the slave (the register file) returns operands and stalls.
interface regfile_sb_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 2
) ();
  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]         rd_stall;
  logic                      iss_valid;
  logic [ADDR_W-1:0]         iss_dst;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*ADDR_W-1:0] fwd_dst;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic                      wb_we;
  logic [ADDR_W-1:0]         wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic                      flush;
  logic                      sb_err;

  modport master (
    output rd_addr, iss_valid, iss_dst, fwd_valid, fwd_dst, fwd_data,
           fwd_ready, wb_we, wb_addr, wb_data, flush,
    input  rd_data, rd_stall, sb_err
  );

  modport slave (
    input  rd_addr, iss_valid, iss_dst, fwd_valid, fwd_dst, fwd_data,
           fwd_ready, wb_we, wb_addr, wb_data, flush,
    output rd_data, rd_stall, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// GPR file with forwarding, multiple read ports and a pending-writer
// scoreboard. Operands resolve combinationally (youngest forwarding stage,
// then same-cycle write-back, then pending-writer stall, then the array).
// Optional feature macro: RF_ZERO_REG_EN -- register 0 reads as 0 and
// ignores writes, issues and write-backs.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]        regs     [DEPTH];
  logic [CNT_W-1:0]         pend     [DEPTH];
  logic [CNT_W-1:0]         pend_nxt [DEPTH];
  logic [ADDR_W-1:0]        ra       [NUM_RD];
  logic [DEPTH-1:0]         inc_v;
  logic [DEPTH-1:0]         dec_v;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_stall_c;
  logic                     err_set;
  logic                     sb_err_q;
  logic                     wb_ok;
  logic                     iss_ok;

  // Register 0 traffic is dropped entirely when it is hardwired.
  assign wb_ok  = bus.wb_we && !(ZERO_REG && bus.wb_addr == '0);
  assign iss_ok = bus.iss_valid && !(ZERO_REG && bus.iss_dst == '0);

  // Operand resolution: lowest priority assigned first so later
  // assignments override; the forwarding loop runs oldest-to-youngest so
  // the youngest matching stage has the final say.
  always_comb begin
    rd_data_c  = '0;
    rd_stall_c = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
      rd_data_c[p*DATA_W +: DATA_W] = regs[ra[p]];
      if (pend[ra[p]] != '0) begin
        rd_data_c[p*DATA_W +: DATA_W] = '0;
        rd_stall_c[p] = 1'b1;
      end
      if (bus.wb_we && bus.wb_addr == ra[p]) begin
        rd_data_c[p*DATA_W +: DATA_W] = bus.wb_data;
        rd_stall_c[p] = 1'b0;
      end
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (bus.fwd_valid[i] && bus.fwd_dst[i*ADDR_W +: ADDR_W] == ra[p]) begin
          rd_data_c[p*DATA_W +: DATA_W] =
            bus.fwd_ready[i] ? bus.fwd_data[i*DATA_W +: DATA_W] : '0;
          rd_stall_c[p] = !bus.fwd_ready[i];
        end
      end
      if (ZERO_REG && ra[p] == '0) begin
        rd_data_c[p*DATA_W +: DATA_W] = '0;
        rd_stall_c[p] = 1'b0;
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_stall = rd_stall_c;
  assign bus.sb_err   = sb_err_q;

  // Scoreboard next state: saturating up/down per register, flush wins.
  always_comb begin
    err_set = 1'b0;
    inc_v   = '0;
    dec_v   = '0;
    for (int r = 0; r < DEPTH; r++) begin
      inc_v[r]    = iss_ok && bus.iss_dst == ADDR_W'(r);
      dec_v[r]    = wb_ok && bus.wb_addr == ADDR_W'(r);
      pend_nxt[r] = pend[r];
      if (bus.flush) begin
        pend_nxt[r] = '0;
      end else if (inc_v[r] && !dec_v[r]) begin
        if (&pend[r]) err_set = 1'b1;
        else          pend_nxt[r] = pend[r] + CNT_W'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        if (pend[r] == '0) err_set = 1'b1;
        else               pend_nxt[r] = pend[r] - CNT_W'(1);
      end
    end
  end

  // Register array write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wb_ok) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Pending-writer counters and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) pend[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) pend[r] <= pend_nxt[r];
      sb_err_q <= sb_err_q | err_set;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_regfile_sb;
  localparam int DATA_W = 32, ADDR_W = 5, NUM_RD = 2, NUM_FWD = 2, CNT_W = 2;
  localparam int DEPTH = 32;
  localparam int PMAX = 3;
`ifdef RF_ZERO_REG_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif
  localparam logic [31:0] Z0FF = Z ? 32'h0 : 32'hFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD)) bus ();
  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [DEPTH];
  int          m_pend [DEPTH];
  bit          m_err;

  typedef struct {
    logic [4:0]  rd0, rd1;
    logic [1:0]  fv;
    logic [4:0]  fd0, fd1;
    logic [31:0] fdat0, fdat1;
    logic [1:0]  fr;
    logic        wb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e0;
    logic        es0;
    logic [31:0] e1;
    logic        es1;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.rd_addr = '0; bus.iss_valid = 0; bus.iss_dst = '0;
    bus.fwd_valid = '0; bus.fwd_dst = '0; bus.fwd_data = '0; bus.fwd_ready = '0;
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.flush = 0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < DEPTH; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
    m_err = 0;
  endtask

  // Reference operand lookup: search the priority list and stop at first hit.
  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic s);
    if (Z && a == 0) begin d = 0; s = 0; return; end
    for (int i = 0; i < NUM_FWD; i++) begin
      if (bus.fwd_valid[i] && bus.fwd_dst[i*5 +: 5] == a) begin
        d = bus.fwd_ready[i] ? bus.fwd_data[i*32 +: 32] : 32'h0;
        s = !bus.fwd_ready[i];
        return;
      end
    end
    if (bus.wb_we && bus.wb_addr == a) begin d = bus.wb_data; s = 0; return; end
    if (m_pend[a] != 0) begin d = 0; s = 1; return; end
    d = m_regs[a]; s = 0;
  endtask

  task automatic model_commit();
    bit wz, iz;
    wz = bus.wb_we && !(Z && bus.wb_addr == 0);
    iz = bus.iss_valid && !(Z && bus.iss_dst == 0);
    if (bus.flush) begin
      for (int r = 0; r < DEPTH; r++) m_pend[r] = 0;
    end else if (!(wz && iz && bus.wb_addr == bus.iss_dst)) begin
      if (iz) begin
        if (m_pend[bus.iss_dst] == PMAX) m_err = 1;
        else m_pend[bus.iss_dst]++;
      end
      if (wz) begin
        if (m_pend[bus.wb_addr] == 0) m_err = 1;
        else m_pend[bus.wb_addr]--;
      end
    end
    if (wz) m_regs[bus.wb_addr] = bus.wb_data;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] d;
    logic s;
    for (int p = 0; p < NUM_RD; p++) begin
      model_read(bus.rd_addr[p*5 +: 5], d, s);
      chk($sformatf("%s rd_data[%0d]", tag, p), bus.rd_data[p*32 +: 32], d);
      chk($sformatf("%s rd_stall[%0d]", tag, p), {31'h0, bus.rd_stall[p]}, {31'h0, s});
    end
    chk({tag, " sb_err"}, {31'h0, bus.sb_err}, {31'h0, m_err});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1; #2; rst = 0;
    model_clear();
  endtask

  task automatic rd0(input logic [4:0] a);
    bus.rd_addr[4:0] = a;
  endtask

  initial begin
    idle();
    model_clear();
    tbl[0] = '{3, 4, 0, 0, 0, 0, 0, 0, 1, 3, 'hA5, 'hA5, 0, 0, 0};
    tbl[1] = '{3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hA5, 0, 0, 0};
    tbl[2] = '{7, 3, 3, 7, 7, 'h11, 'h22, 3, 0, 0, 0, 'h11, 0, 'hA5, 0};
    tbl[3] = '{7, 3, 3, 7, 7, 'h11, 'h22, 2, 0, 0, 0, 0, 1, 'hA5, 0};
    tbl[4] = '{7, 3, 2, 0, 7, 0, 'h22, 2, 0, 0, 0, 'h22, 0, 'hA5, 0};
    tbl[5] = '{3, 3, 1, 3, 0, 'h33, 0, 1, 1, 3, 'h44, 'h33, 0, 'h33, 0};
    tbl[6] = '{3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h44, 0, 'h44, 0};
    tbl[7] = '{0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 'hFF, Z0FF, 0, 'h44, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z0FF, 0, Z0FF, 0};

    @(negedge clk);
    rst = 0;
    #1;
    chk("reset rd_data[0]", bus.rd_data[31:0], 0);
    chk("reset rd_stall", {30'h0, bus.rd_stall}, 0);
    chk("reset sb_err", {31'h0, bus.sb_err}, 0);
    @(negedge clk);

    // Directed table
    for (int k = 0; k < 9; k++) begin
      idle();
      bus.rd_addr = {tbl[k].rd1, tbl[k].rd0};
      bus.fwd_valid = tbl[k].fv;
      bus.fwd_dst = {tbl[k].fd1, tbl[k].fd0};
      bus.fwd_data = {tbl[k].fdat1, tbl[k].fdat0};
      bus.fwd_ready = tbl[k].fr;
      bus.wb_we = tbl[k].wb; bus.wb_addr = tbl[k].wa; bus.wb_data = tbl[k].wd;
      #1;
      chk($sformatf("tbl%0d d0", k), bus.rd_data[31:0], tbl[k].e0);
      chk($sformatf("tbl%0d s0", k), {31'h0, bus.rd_stall[0]}, {31'h0, tbl[k].es0});
      chk($sformatf("tbl%0d d1", k), bus.rd_data[63:32], tbl[k].e1);
      chk($sformatf("tbl%0d s1", k), {31'h0, bus.rd_stall[1]}, {31'h0, tbl[k].es1});
      cyc();
    end

    // Issue then write-back of a pending register
    do_reset();
    bus.iss_valid = 1; bus.iss_dst = 5; rd0(5); #1;
    chk("iss same-cycle stall", {31'h0, bus.rd_stall[0]}, 0);
    cyc();
    idle(); rd0(5); #1;
    chk("pending stall", {31'h0, bus.rd_stall[0]}, 1);
    cyc();
    bus.wb_we = 1; bus.wb_addr = 5; bus.wb_data = 9; #1;
    chk("wb through data", bus.rd_data[31:0], 9);
    chk("wb through stall", {31'h0, bus.rd_stall[0]}, 0);
    cyc();
    idle(); rd0(5); #1;
    chk("after wb data", bus.rd_data[31:0], 9);
    chk("after wb stall", {31'h0, bus.rd_stall[0]}, 0);

    // Counter saturation and underflow
    do_reset();
    for (int k = 0; k < 4; k++) begin bus.iss_valid = 1; bus.iss_dst = 6; cyc(); end
    idle(); rd0(6); #1;
    chk("overflow sb_err", {31'h0, bus.sb_err}, 1);
    chk("overflow stall", {31'h0, bus.rd_stall[0]}, 1);
    for (int k = 0; k < 3; k++) begin
      bus.wb_we = 1; bus.wb_addr = 6; bus.wb_data = k; cyc();
      idle(); rd0(6); #1;
      chk($sformatf("drain%0d stall", k), {31'h0, bus.rd_stall[0]}, (k == 2) ? 0 : 1);
    end
    do_reset(); #1;
    chk("sb_err cleared by rst", {31'h0, bus.sb_err}, 0);
    bus.wb_we = 1; bus.wb_addr = 2; bus.wb_data = 1; cyc();
    idle(); #1;
    chk("underflow sb_err", {31'h0, bus.sb_err}, 1);

    // Flush overrides issue, write-back still lands
    do_reset();
    for (int k = 0; k < 2; k++) begin bus.iss_valid = 1; bus.iss_dst = 4; cyc(); end
    idle(); rd0(4); #1;
    chk("pend2 stall", {31'h0, bus.rd_stall[0]}, 1);
    bus.flush = 1; bus.iss_valid = 1; bus.iss_dst = 4;
    bus.wb_we = 1; bus.wb_addr = 4; bus.wb_data = 7;
    cyc();
    idle(); rd0(4); #1;
    chk("flush data", bus.rd_data[31:0], 7);
    chk("flush stall", {31'h0, bus.rd_stall[0]}, 0);
    chk("flush sb_err", {31'h0, bus.sb_err}, 0);

    // Register 0 behaviour
    do_reset();
    bus.wb_we = 1; bus.wb_addr = 0; bus.wb_data = 32'hFF;
    bus.iss_valid = 1; bus.iss_dst = 0;
    cyc();
    idle(); rd0(0); #1;
    chk("reg0 data", bus.rd_data[31:0], Z0FF);
    chk("reg0 stall", {31'h0, bus.rd_stall[0]}, 0);
    chk("reg0 sb_err", {31'h0, bus.sb_err}, 0);

    // Reset mid-operation drops the in-flight commit
    do_reset();
    bus.wb_we = 1; bus.wb_addr = 9; bus.wb_data = 32'h55; cyc();
    bus.wb_addr = 10; bus.wb_data = 32'h66;
    #2 rst = 1;
    #1 idle();
    #1 rst = 0;
    model_clear();
    cyc();
    rd0(9); bus.rd_addr[9:5] = 10; #1;
    chk("mid rst reg9", bus.rd_data[31:0], 0);
    chk("mid rst reg10", bus.rd_data[63:32], 0);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 149) do_reset();
      bus.rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.iss_valid = ($urandom_range(0, 1) == 1);
      bus.iss_dst   = 5'($urandom_range(0, 7));
      bus.fwd_valid = 2'($urandom);
      bus.fwd_dst   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.fwd_data  = {$urandom, $urandom};
      bus.fwd_ready = 2'($urandom);
      bus.wb_we     = ($urandom_range(0, 9) < 4);
      bus.wb_addr   = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.flush     = ($urandom_range(0, 31) == 0);
      #1;
      check_model("rand");
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
